// File: rtl/prefetch_queue.sv
// Parametrised byte prefetch queue: word fetches from the bus unit, variable-size retire to the pre-decoder.
// Optional macro PREFETCH_BYPASS_EN: fetched bytes are visible (and consumable) in the ack cycle when the queue is empty.
module prefetch_queue #(
  parameter int DEPTH     = 6,
  parameter int BUS_BYTES = 2,
  parameter int PEEK      = 6,
  parameter int CW        = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [15:0]            flush_ip,
  output logic                   fetch_req,
  output logic [15:0]            fetch_addr,
  input  logic                   fetch_ack,
  input  logic [8*BUS_BYTES-1:0] fetch_data,
  output logic [8*PEEK-1:0]      peek_data,
  output logic [CW-1:0]          peek_count,
  output logic [CW-1:0]          level,
  input  logic                   consume_en,
  input  logic [3:0]             consume_size,
  output logic                   underflow
);
  localparam int SW = CW + 2;

  typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_e;

  state_e            state_q;
  logic              fetch_req_q;
  logic [15:0]       fetch_addr_q;
  logic [15:0]       fetch_ip_q;
  logic [7:0]        mem_q [DEPTH];
  logic [CW-1:0]     rd_ptr_q;
  logic [CW-1:0]     wr_ptr_q;
  logic [CW-1:0]     count_q;
  logic              skip_low_q;
  logic              drop_q;
  logic              underflow_q;

  logic              fill_v_s;
  logic              bypass_s;
  logic              under_s;
  logic [SW-1:0]     n_fill_s;
  logic [SW-1:0]     fill_n_s;
  logic [SW-1:0]     avail_s;
  logic [SW-1:0]     size_s;
  logic [SW-1:0]     n_cons_s;
  logic [8*BUS_BYTES-1:0]          fill_bytes_s;
  logic [8*(PEEK+BUS_BYTES)-1:0]   fill_ext_s;

  // Pointers wrap at DEPTH; sums never exceed 2*DEPTH-1, so one subtraction suffices.
  function automatic logic [CW-1:0] wrap(input logic [SW-1:0] s);
    logic [SW-1:0] r;
    r = (s >= SW'(DEPTH)) ? s - SW'(DEPTH) : s;
    return r[CW-1:0];
  endfunction

  // Fill and retire amounts for this cycle.
  always_comb begin
    fill_v_s = (state_q == S_REQ) && fetch_ack && !drop_q && !flush;
    if (skip_low_q) begin
      n_fill_s     = SW'(BUS_BYTES - 1);
      fill_bytes_s = fetch_data >> 8;
    end else begin
      n_fill_s     = SW'(BUS_BYTES);
      fill_bytes_s = fetch_data;
    end
    fill_n_s   = fill_v_s ? n_fill_s : '0;
    fill_ext_s = {{(8*PEEK){1'b0}}, fill_bytes_s};
`ifdef PREFETCH_BYPASS_EN
    bypass_s = fill_v_s && (count_q == '0);
`else
    bypass_s = 1'b0;
`endif
    avail_s = SW'(count_q) + (bypass_s ? fill_n_s : '0);
    size_s  = SW'(consume_size);
    if (!consume_en || flush) begin
      n_cons_s = '0;
      under_s  = 1'b0;
    end else if (size_s > avail_s) begin
      n_cons_s = avail_s;
      under_s  = 1'b1;
    end else begin
      n_cons_s = size_s;
      under_s  = 1'b0;
    end
  end

  // Storage, pointers, count and fetch IP; flush overrides fill and consume.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      fetch_ip_q  <= 16'h0000;
      skip_low_q  <= 1'b0;
      underflow_q <= 1'b0;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= 8'h00;
    end else if (flush) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      fetch_ip_q <= (BUS_BYTES == 2) ? {flush_ip[15:1], 1'b0} : flush_ip;
      skip_low_q <= flush_ip[0] && (BUS_BYTES == 2);
    end else begin
      if (fill_v_s) begin
        for (int j = 0; j < BUS_BYTES; j++) begin
          if (SW'(j) < n_fill_s) mem_q[wrap(SW'(wr_ptr_q) + SW'(j))] <= fill_bytes_s[8*j +: 8];
        end
        wr_ptr_q   <= wrap(SW'(wr_ptr_q) + n_fill_s);
        fetch_ip_q <= fetch_ip_q + 16'(BUS_BYTES);
        skip_low_q <= 1'b0;
      end
      rd_ptr_q <= wrap(SW'(rd_ptr_q) + n_cons_s);
      count_q  <= CW'(SW'(count_q) + fill_n_s - n_cons_s);
      if (under_s) underflow_q <= 1'b1;
    end
  end

  // Request FSM; drop_q marks a request orphaned by flush whose data must be discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      fetch_req_q  <= 1'b0;
      fetch_addr_q <= 16'h0000;
      drop_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!flush && (SW'(DEPTH) - SW'(count_q) >= SW'(BUS_BYTES))) begin
            state_q      <= S_REQ;
            fetch_req_q  <= 1'b1;
            fetch_addr_q <= fetch_ip_q;
          end
        end
        S_REQ: begin
          if (fetch_ack) begin
            state_q     <= S_IDLE;
            fetch_req_q <= 1'b0;
            drop_q      <= 1'b0;
          end else if (flush) begin
            drop_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          fetch_req_q <= 1'b0;
          drop_q      <= 1'b0;
        end
      endcase
    end
  end

  // Head window; slots beyond the held count read as zero.
  always_comb begin
    peek_data = '0;
    for (int i = 0; i < PEEK; i++) begin
      if (bypass_s) begin
        if (SW'(i) < fill_n_s) peek_data[8*i +: 8] = fill_ext_s[8*i +: 8];
        else peek_data[8*i +: 8] = 8'h00;
      end else if (SW'(i) < SW'(count_q)) begin
        peek_data[8*i +: 8] = mem_q[wrap(SW'(rd_ptr_q) + SW'(i))];
      end else begin
        peek_data[8*i +: 8] = 8'h00;
      end
    end
    if (bypass_s) peek_count = CW'(fill_n_s);
    else if (SW'(count_q) > SW'(PEEK)) peek_count = CW'(PEEK);
    else peek_count = count_q;
  end

  assign fetch_req  = fetch_req_q;
  assign fetch_addr = fetch_addr_q;
  assign level      = count_q;
  assign underflow  = underflow_q;
endmodule

// File: tb/tb_prefetch_queue.sv
// Directed vector bench for prefetch_queue at DEPTH=6, BUS_BYTES=2, PEEK=6.
module tb_prefetch_queue;
  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [15:0] flush_ip;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_ack;
  logic [15:0] fetch_data;
  logic [47:0] peek_data;
  logic [2:0]  peek_count;
  logic [2:0]  level;
  logic        consume_en;
  logic [3:0]  consume_size;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  prefetch_queue #(.DEPTH(6), .BUS_BYTES(2), .PEEK(6)) dut (
    .clk(clk), .reset(reset), .flush(flush), .flush_ip(flush_ip),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
    .fetch_data(fetch_data), .peek_data(peek_data), .peek_count(peek_count),
    .level(level), .consume_en(consume_en), .consume_size(consume_size),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic [15:0] fip;
    logic        ack;
    logic [15:0] dat;
    logic        ce;
    logic [3:0]  cs;
    logic        req;
    logic [15:0] addr;
    logic [2:0]  lvl;
    logic [2:0]  pc;
    logic [47:0] pk;
    logic        uf;
  } vec_t;

  vec_t vecs [26];

  function automatic vec_t mk(input logic fl, input logic [15:0] fip, input logic ack,
                              input logic [15:0] dat, input logic ce, input logic [3:0] cs,
                              input logic req, input logic [15:0] addr, input logic [2:0] lvl,
                              input logic [2:0] pc, input logic [47:0] pk, input logic uf);
    vec_t v;
    v.fl = fl; v.fip = fip; v.ack = ack; v.dat = dat; v.ce = ce; v.cs = cs;
    v.req = req; v.addr = addr; v.lvl = lvl; v.pc = pc; v.pk = pk; v.uf = uf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic [15:0] fip, input logic ack,
                       input logic [15:0] dat, input logic ce, input logic [3:0] cs);
    flush = fl; flush_ip = fip; fetch_ack = ack; fetch_data = dat;
    consume_en = ce; consume_size = cs;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int waited;
    //                fl  fip       ack dat       ce cs    req addr      lvl pc pk                  uf
    vecs[0]  = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b1, 16'h0000, 3'd0, 3'd0, 48'h0, 1'b0);
    vecs[1]  = mk(1'b0, 16'h0000, 1'b1, 16'h3412, 1'b0, 4'd0, 1'b0, 16'h0000, 3'd2, 3'd2, 48'h3412, 1'b0);
    vecs[2]  = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b1, 16'h0002, 3'd2, 3'd2, 48'h3412, 1'b0);
    vecs[3]  = mk(1'b0, 16'h0000, 1'b1, 16'h7856, 1'b0, 4'd0, 1'b0, 16'h0000, 3'd4, 3'd4, 48'h78563412, 1'b0);
    vecs[4]  = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b1, 16'h0004, 3'd4, 3'd4, 48'h78563412, 1'b0);
    vecs[5]  = mk(1'b0, 16'h0000, 1'b1, 16'hBC9A, 1'b0, 4'd0, 1'b0, 16'h0000, 3'd6, 3'd6, 48'hBC9A78563412, 1'b0);
    vecs[6]  = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 16'h0000, 3'd6, 3'd6, 48'hBC9A78563412, 1'b0);
    vecs[7]  = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 16'h0000, 3'd6, 3'd6, 48'hBC9A78563412, 1'b0);
    vecs[8]  = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 4'd3, 1'b0, 16'h0000, 3'd3, 3'd3, 48'hBC9A78, 1'b0);
    vecs[9]  = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b1, 16'h0006, 3'd3, 3'd3, 48'hBC9A78, 1'b0);
    vecs[10] = mk(1'b0, 16'h0000, 1'b1, 16'h2211, 1'b1, 4'd2, 1'b0, 16'h0000, 3'd3, 3'd3, 48'h2211BC, 1'b0);
    vecs[11] = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b1, 16'h0008, 3'd3, 3'd3, 48'h2211BC, 1'b0);
    vecs[12] = mk(1'b1, 16'h1001, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b1, 16'h0008, 3'd0, 3'd0, 48'h0, 1'b0);
    vecs[13] = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b1, 16'h0008, 3'd0, 3'd0, 48'h0, 1'b0);
    vecs[14] = mk(1'b0, 16'h0000, 1'b1, 16'hDEAD, 1'b0, 4'd0, 1'b0, 16'h0000, 3'd0, 3'd0, 48'h0, 1'b0);
    vecs[15] = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b1, 16'h1000, 3'd0, 3'd0, 48'h0, 1'b0);
    vecs[16] = mk(1'b0, 16'h0000, 1'b1, 16'hAA55, 1'b0, 4'd0, 1'b0, 16'h0000, 3'd1, 3'd1, 48'hAA, 1'b0);
    vecs[17] = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b1, 16'h1002, 3'd1, 3'd1, 48'hAA, 1'b0);
    vecs[18] = mk(1'b0, 16'h0000, 1'b1, 16'h4433, 1'b0, 4'd0, 1'b0, 16'h0000, 3'd3, 3'd3, 48'h4433AA, 1'b0);
    vecs[19] = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 4'd1, 1'b1, 16'h1004, 3'd2, 3'd2, 48'h4433, 1'b0);
    vecs[20] = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 4'd4, 1'b1, 16'h1004, 3'd0, 3'd0, 48'h0, 1'b1);
    vecs[21] = mk(1'b1, 16'hFFFE, 1'b1, 16'h9999, 1'b0, 4'd0, 1'b0, 16'h0000, 3'd0, 3'd0, 48'h0, 1'b1);
    vecs[22] = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b1, 16'hFFFE, 3'd0, 3'd0, 48'h0, 1'b1);
    vecs[23] = mk(1'b0, 16'h0000, 1'b1, 16'h6655, 1'b0, 4'd0, 1'b0, 16'h0000, 3'd2, 3'd2, 48'h6655, 1'b1);
    vecs[24] = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b1, 16'h0000, 3'd2, 3'd2, 48'h6655, 1'b1);
    vecs[25] = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 4'd0, 1'b1, 16'h0000, 3'd2, 3'd2, 48'h6655, 1'b1);

    reset = 1'b1;
    drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'd0);
    #2;
    chk("rst_req", 64'(fetch_req), 64'h0);
    chk("rst_level", 64'(level), 64'h0);
    chk("rst_peek_count", 64'(peek_count), 64'h0);
    chk("rst_peek_data", 64'(peek_data), 64'h0);
    chk("rst_underflow", 64'(underflow), 64'h0);
    #10;
    reset = 1'b0;

    for (int i = 0; i < 26; i++) begin
      drive(vecs[i].fl, vecs[i].fip, vecs[i].ack, vecs[i].dat, vecs[i].ce, vecs[i].cs);
      step();
      chk($sformatf("v%0d_req", i), 64'(fetch_req), 64'(vecs[i].req));
      if (vecs[i].req) chk($sformatf("v%0d_addr", i), 64'(fetch_addr), 64'(vecs[i].addr));
      chk($sformatf("v%0d_level", i), 64'(level), 64'(vecs[i].lvl));
      chk($sformatf("v%0d_peek_count", i), 64'(peek_count), 64'(vecs[i].pc));
      chk($sformatf("v%0d_peek_data", i), 64'(peek_data), 64'(vecs[i].pk));
      chk($sformatf("v%0d_underflow", i), 64'(underflow), 64'(vecs[i].uf));
    end

    // Empty the queue via flush of a pending request, then land a fetch on an empty queue with a same-cycle consume.
    drive(1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'd0);
    step();
    chk("byp_flush_level", 64'(level), 64'h0);
    drive(1'b0, 16'h0000, 1'b1, 16'hDEAD, 1'b0, 4'd0);
    step();
    chk("byp_drop_level", 64'(level), 64'h0);
    drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'd0);
    waited = 0;
    while (!fetch_req && waited < 10) begin
      step();
      waited++;
    end
    chk("byp_req_wait", 64'(fetch_req), 64'h1);
    chk("byp_req_addr", 64'(fetch_addr), 64'h0);
    drive(1'b0, 16'h0000, 1'b1, 16'h0890, 1'b1, 4'd1);
    #1;
`ifdef PREFETCH_BYPASS_EN
    chk("byp_same_cycle_count", 64'(peek_count), 64'h2);
    chk("byp_same_cycle_byte0", 64'(peek_data[7:0]), 64'h90);
    step();
    drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'd0);
    chk("byp_after_level", 64'(level), 64'h1);
    chk("byp_after_peek", 64'(peek_data), 64'h08);
`else
    chk("nobyp_same_cycle_count", 64'(peek_count), 64'h0);
    chk("nobyp_same_cycle_data", 64'(peek_data), 64'h0);
    step();
    drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'd0);
    chk("nobyp_after_level", 64'(level), 64'h2);
    chk("nobyp_after_peek", 64'(peek_data), 64'h0890);
`endif
    chk("byp_after_underflow", 64'(underflow), 64'h1);

    // Asynchronous reset mid-cycle clears state without a clock edge.
    #3;
    reset = 1'b1;
    #1;
    chk("arst_level", 64'(level), 64'h0);
    chk("arst_req", 64'(fetch_req), 64'h0);
    chk("arst_underflow", 64'(underflow), 64'h0);
    chk("arst_peek_count", 64'(peek_count), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
